prime_pair_generator: RTL and testbench
=======================================

Name: prime_pair_generator

Overview:
- Next-generation RSA prime-pair source. Draws odd, full-width HALF-bit candidates (HALF = WORD_WIDTH/2) from an internal Galois LFSR.
- Rejects cheap composites with a small-prime sieve. Hands each survivor to an external primality tester (Miller-Rabin) over a start/done handshake.
- Returns distinct primes P and Q for the modulus stage.
- Adds over its predecessor: configurable test rounds, a per-prime attempt budget with an error exit, guaranteed MSB-set candidates, and registered, well-defined outputs.

Parameters:
- WORD_WIDTH, 32, RSA modulus width. Primes are HALF = WORD_WIDTH/2 bits. HALF must be at least 8.
- MR_ROUNDS, 2, round count driven on test_rounds. Range 1..15.
- MAX_ATTEMPTS, 64, maximum candidates drawn per prime, counting sieve rejections.
- LFSR_TAPS, 'hB400, Galois feedback mask, HALF bits wide. The 16-bit default is maximal-length. Use 'hB8 for HALF=8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin generation. Sampled only in IDLE.
- seed  in  HALF  LFSR seed, loaded on start. 0 is replaced by 1.
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at completion (success or error)
- error  out  1  attempt budget exhausted. Held until next start.
- valid  out  1  P/Q hold a valid pair. Held until next start.
- P  out  HALF  first prime
- Q  out  HALF  second prime, never equal to P
- test_start  out  1  one-cycle pulse requesting a primality test
- test_n  out  HALF  candidate under test. Stable from test_start until test_done.
- test_rounds  out  4  constant MR_ROUNDS
- test_done  in  1  tester completion pulse. Any latency of 1 cycle or more.
- test_is_prime  in  1  tester verdict, valid with test_done

Behaviour:
- Reset: state=IDLE. busy, done, error, valid, test_start are 0. P, Q, test_n, LFSR are 0. Attempt counter is 0 and phase (P/Q) is P.
- Reset is synchronous and overrides everything. It aborts mid-test, and any later test_done is ignored.
- LFSR steps every cycle while busy:
  - If lfsr[0] is 1: lfsr = (lfsr >> 1) ^ LFSR_TAPS.
  - Otherwise: lfsr = lfsr >> 1.
- Candidate = lfsr | (1 << (HALF-1)) | 1, i.e. MSB and LSB forced.
- Attempt counter width is $clog2(MAX_ATTEMPTS+1).
- States:
  - IDLE:
    - On start: lfsr <= (seed==0 ? 1 : seed); P, Q, error, valid <= 0; phase <= P; attempts <= 0; busy <= 1. Go to DRAW.
    - start while busy is ignored.
  - DRAW:
    - If attempts == MAX_ATTEMPTS: go to FAIL.
    - Otherwise: cand <= candidate; attempts++; go to SIEVE.
  - SIEVE (1 cycle, combinational remainder against constants):
    - If cand is divisible by 3, 5, 7, 11 or 13: go to DRAW.
    - Else if phase == Q and cand == P: go to DRAW.
    - Else: test_n <= cand; pulse test_start; go to WAIT.
  - WAIT:
    - Hold test_n. Ignore everything until test_done.
    - On test_done with is_prime = 1 and phase P: P <= cand; phase <= Q; attempts <= 0; go to DRAW.
    - On test_done with is_prime = 1 and phase Q: Q <= cand; go to OK.
    - On test_done with is_prime = 0: go to DRAW.
  - OK: done=1, valid=1, busy=0. Go to IDLE.
  - FAIL: done=1, error=1, P=Q=0, busy=0. Go to IDLE.
- test_done outside WAIT is ignored.
- test_start never re-asserts before test_done for the outstanding request.
- Minimum latency from start to done: each prime costs 3 cycles (DRAW, SIEVE, 1-cycle WAIT), plus 1 for the start cycle and 1 for OK. That is 8 cycles when the first two candidates pass.

Test Plan:
- WORD_WIDTH=16, LFSR_TAPS='hB8, seed=8'h01, reference tester model with 3-cycle latency. Required:
  - done pulses exactly once; valid=1, error=0.
  - P and Q are both prime and in 129..255.
  - P != Q.
  - P matches the golden LFSR replay.
- Same setup, monitor every test_start. Required:
  - test_n is never divisible by 3, 5, 7, 11 or 13 (e.g. 135 and 141 are never issued).
  - test_n always has bit 7 and bit 0 set.
- Tester always returns not-prime, MAX_ATTEMPTS=4. Required:
  - error=1 with a done pulse, valid=0, P=Q=0.
  - At most 4 test_start pulses.
- Tester reports prime only for 251, MAX_ATTEMPTS=255. Required:
  - P=251.
  - During the Q phase, test_n is never 251.
  - Finishes with error=1.
- Assert rst during WAIT, then pulse test_done 2 cycles later. Required:
  - All outputs at reset values; the late pulse is ignored.
  - A subsequent start with seed=0 behaves exactly like seed=1.
- Pulse start repeatedly while busy, with tester latency 10. Required:
  - No restart.
  - test_n stays stable through WAIT.
  - Exactly one done pulse.

Source files
------------

// File: rtl/prime_pair_generator.sv
// ---------------------------------------------------------------------------
// prime_pair_generator
//   Produces a pair of distinct HALF-bit primes (HALF = WORD_WIDTH/2) for an
//   RSA modulus stage. Candidates come from a free-running Galois LFSR with
//   the MSB and LSB forced high. A small-prime sieve (3,5,7,11,13) drops cheap
//   composites. Each survivor goes to an external primality tester over a
//   start/done handshake. Each prime has an attempt budget. Running out of
//   budget ends the run with an error.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_seed       begin a run (IDLE only) with an LFSR seed (0 -> 1)
//   o_busy                run in progress
//   o_done                one-cycle completion pulse
//   o_error, o_valid      outcome flags, held until the next start
//   o_p, o_q              resulting primes (zero on error)
//   o_test_start          one-cycle request to the primality tester
//   o_test_n              candidate under test, stable while waiting
//   o_test_rounds         Miller-Rabin round count (constant MR_ROUNDS)
//   i_test_done           tester completion pulse
//   i_test_is_prime       tester verdict, valid with i_test_done
// ---------------------------------------------------------------------------
module prime_pair_generator #(
  parameter int                    WORD_WIDTH   = 32,
  parameter int                    MR_ROUNDS    = 2,
  parameter int                    MAX_ATTEMPTS = 64,
  parameter logic [WORD_WIDTH/2-1:0] LFSR_TAPS  = 16'hB400
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [WORD_WIDTH/2-1:0] i_seed,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic                    o_valid,
  output logic [WORD_WIDTH/2-1:0] o_p,
  output logic [WORD_WIDTH/2-1:0] o_q,
  output logic                    o_test_start,
  output logic [WORD_WIDTH/2-1:0] o_test_n,
  output logic [3:0]              o_test_rounds,
  input  logic                    i_test_done,
  input  logic                    i_test_is_prime
);

  localparam int HALF = WORD_WIDTH / 2;
  localparam int AW   = $clog2(MAX_ATTEMPTS + 1);
  // Forces a full-width, odd candidate.
  localparam logic [HALF-1:0] FORCE_MASK = {1'b1, {(HALF-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_SIEVE,
    S_WAIT,
    S_OK,
    S_FAIL
  } state_t;

  state_t          r_state;
  logic [HALF-1:0] r_lfsr;
  logic [HALF-1:0] r_cand;
  logic [AW-1:0]   r_attempts;
  logic            r_phase_q;   // 0: searching for P, 1: searching for Q
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_valid;
  logic [HALF-1:0] r_p;
  logic [HALF-1:0] r_q;
  logic            r_test_start;
  logic [HALF-1:0] r_test_n;

  logic [HALF-1:0] w_lfsr_next;
  logic [HALF-1:0] w_candidate;
  logic [HALF-1:0] w_seed_eff;

  // The sieve divides by constants only, so each remainder is a fixed network.
  function automatic logic has_small_factor(input logic [HALF-1:0] n);
    logic r;
    r = ((n % HALF'(3))  == '0) |
        ((n % HALF'(5))  == '0) |
        ((n % HALF'(7))  == '0) |
        ((n % HALF'(11)) == '0) |
        ((n % HALF'(13)) == '0);
    return r;
  endfunction

  // Right-shifting Galois step. The taps are folded in when the bit shifted
  // out is 1.
  function automatic logic [HALF-1:0] lfsr_step(input logic [HALF-1:0] s);
    logic [HALF-1:0] r;
    if (s[0]) begin
      r = {1'b0, s[HALF-1:1]} ^ LFSR_TAPS;
    end else begin
      r = {1'b0, s[HALF-1:1]};
    end
    return r;
  endfunction

  assign w_lfsr_next = lfsr_step(r_lfsr);
  assign w_candidate = r_lfsr | FORCE_MASK;
  assign w_seed_eff  = (i_seed == '0) ? {{(HALF-1){1'b0}}, 1'b1} : i_seed;

  // Sequencer: candidate draw, sieve, tester handshake and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= '0;
      r_cand       <= '0;
      r_attempts   <= '0;
      r_phase_q    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_valid      <= 1'b0;
      r_p          <= '0;
      r_q          <= '0;
      r_test_start <= 1'b0;
      r_test_n     <= '0;
    end else begin
      r_done       <= 1'b0;
      r_test_start <= 1'b0;
      // The LFSR keeps running throughout a run, so candidate order depends on
      // tester latency as well as the seed.
      if (r_busy) begin
        r_lfsr <= w_lfsr_next;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_lfsr     <= w_seed_eff;
            r_p        <= '0;
            r_q        <= '0;
            r_error    <= 1'b0;
            r_valid    <= 1'b0;
            r_phase_q  <= 1'b0;
            r_attempts <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (r_attempts == AW'(MAX_ATTEMPTS)) begin
            r_state <= S_FAIL;
          end else begin
            r_cand     <= w_candidate;
            r_attempts <= r_attempts + AW'(1);
            r_state    <= S_SIEVE;
          end
        end
        S_SIEVE: begin
          if (has_small_factor(r_cand)) begin
            r_state <= S_DRAW;
          end else if (r_phase_q && (r_cand == r_p)) begin
            // Q must differ from P, so do not test P again.
            r_state <= S_DRAW;
          end else begin
            r_test_n     <= r_cand;
            r_test_start <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_test_done) begin
            if (!i_test_is_prime) begin
              r_state <= S_DRAW;
            end else if (!r_phase_q) begin
              r_p        <= r_cand;
              r_phase_q  <= 1'b1;
              r_attempts <= '0;
              r_state    <= S_DRAW;
            end else begin
              r_q     <= r_cand;
              r_state <= S_OK;
            end
          end
        end
        S_OK: begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          r_done  <= 1'b1;
          r_error <= 1'b1;
          r_p     <= '0;
          r_q     <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_valid       = r_valid;
  assign o_p           = r_p;
  assign o_q           = r_q;
  assign o_test_start  = r_test_start;
  assign o_test_n      = r_test_n;
  assign o_test_rounds = 4'(MR_ROUNDS);

endmodule

// File: tb/tb_prime_pair_generator.sv
// ---------------------------------------------------------------------------
// tb_prime_pair_generator
//   Two instances with HALF=8 and taps 8'hB8. Instance A has a budget of 255
//   attempts. Instance B has a budget of 4 attempts. They share the inputs.
//   A select bit chooses which instance's outputs are observed.
//   The reference model replays the LFSR sequence from the seed. It walks the
//   draw/sieve/test rules forward to predict each tester request and the
//   completion cycle.
// ---------------------------------------------------------------------------
module tb_prime_pair_generator;

  localparam int MAX_A = 255;
  localparam int MAX_B = 4;
  localparam int LIMIT = 6000;

  localparam int EV_NONE = 0;
  localparam int EV_TEST = 1;
  localparam int EV_OK   = 2;
  localparam int EV_ERR  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       test_done = 1'b0;
  logic       test_is_prime = 1'b0;
  logic       sel = 1'b0;

  logic       a_busy, a_done, a_error, a_valid, a_ts;
  logic [7:0] a_p, a_q, a_tn;
  logic [3:0] a_rounds;
  logic       b_busy, b_done, b_error, b_valid, b_ts;
  logic [7:0] b_p, b_q, b_tn;
  logic [3:0] b_rounds;

  prime_pair_generator #(
    .WORD_WIDTH(16), .MR_ROUNDS(2), .MAX_ATTEMPTS(MAX_A), .LFSR_TAPS(8'hB8)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_seed(seed),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_error), .o_valid(a_valid),
    .o_p(a_p), .o_q(a_q), .o_test_start(a_ts), .o_test_n(a_tn),
    .o_test_rounds(a_rounds), .i_test_done(test_done), .i_test_is_prime(test_is_prime)
  );

  prime_pair_generator #(
    .WORD_WIDTH(16), .MR_ROUNDS(5), .MAX_ATTEMPTS(MAX_B), .LFSR_TAPS(8'hB8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_seed(seed),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error), .o_valid(b_valid),
    .o_p(b_p), .o_q(b_q), .o_test_start(b_ts), .o_test_n(b_tn),
    .o_test_rounds(b_rounds), .i_test_done(test_done), .i_test_is_prime(test_is_prime)
  );

  logic       busy_m, done_m, error_m, valid_m, ts_m;
  logic [7:0] p_m, q_m, tn_m;
  assign busy_m  = sel ? b_busy  : a_busy;
  assign done_m  = sel ? b_done  : a_done;
  assign error_m = sel ? b_error : a_error;
  assign valid_m = sel ? b_valid : a_valid;
  assign ts_m    = sel ? b_ts    : a_ts;
  assign p_m     = sel ? b_p     : a_p;
  assign q_m     = sel ? b_q     : a_q;
  assign tn_m    = sel ? b_tn    : a_tn;

  int n_checks = 0;
  int n_fail   = 0;
  int seq [0:8191];

  typedef struct {
    logic [7:0] seed;
    bit         sel;
    int         mode;       // 0 true primes, 1 never prime, 2 only 251, 3 random
    int         lat;
    bit         spam;
    bit         stray;
    int         exp_valid;  // -1: decided by the model only
    int         exp_error;
  } scen_t;

  scen_t tbl [0:6];

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_prime_f(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit sieved(input int n);
    return (n % 3 == 0) || (n % 5 == 0) || (n % 7 == 0) || (n % 11 == 0) || (n % 13 == 0);
  endfunction

  // Walk draws forward from edge dedge until the next tester request or budget exhaustion.
  function automatic void predict(inout int dedge, inout int att, input int phase, input int pp,
                                  input int maxa, output int evt, output int ecyc, output int en);
    evt = EV_NONE; ecyc = 0; en = 0;
    for (int k = 0; k <= maxa + 1; k++) begin
      if (att == maxa) begin
        evt = EV_ERR; ecyc = dedge + 1;
        return;
      end
      en = seq[dedge - 1] | 8'h81;
      att++;
      if (sieved(en) || (phase == 1 && en == pp)) begin
        dedge += 2;
      end else begin
        evt = EV_TEST; ecyc = dedge + 1;
        return;
      end
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check(busy_m == 1'b0 && done_m == 1'b0 && error_m == 1'b0 && valid_m == 1'b0,
          {tag, " flags"}, {busy_m, done_m, error_m, valid_m}, 0);
    check(ts_m == 1'b0, {tag, " test_start"}, ts_m, 0);
    check(p_m == 8'd0 && q_m == 8'd0, {tag, " P/Q"}, {p_m, q_m}, 0);
    check(tn_m == 8'd0, {tag, " test_n"}, tn_m, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; test_done = 1'b0; test_is_prime = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");
  endtask

  task automatic run_scen(input scen_t s, input bit do_reset, output int r_p, output int r_q, output int r_dc);
    int maxa, cyc, m_edge, m_att, m_phase, m_p, m_q, exp_evt, exp_cyc, exp_n;
    int done_cyc, start_cyc, cur_n, hold_n, n_starts, n_dones, fin_cyc;
    bit waiting, verdict, finished, at_end;
    maxa = s.sel ? MAX_B : MAX_A;
    sel = s.sel;
    r_p = 0; r_q = 0; r_dc = -1;
    if (do_reset) apply_reset();
    seq[0] = (s.seed == 8'd0) ? 1 : int'(s.seed);
    for (int i = 1; i < 8192; i++) begin
      seq[i] = (seq[i-1] % 2 == 1) ? ((seq[i-1] / 2) ^ 'hB8) : (seq[i-1] / 2);
    end
    @(negedge clk);
    start = 1'b1; seed = s.seed;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; m_edge = 1; m_att = 0; m_phase = 0; m_p = 0; m_q = 0;
    waiting = 1'b0; verdict = 1'b0; finished = 1'b0; n_starts = 0; n_dones = 0;
    fin_cyc = 0; done_cyc = 0; start_cyc = 0; cur_n = 0; hold_n = 0;
    predict(m_edge, m_att, m_phase, m_p, maxa, exp_evt, exp_cyc, exp_n);
    while (cyc < LIMIT && !(finished && cyc >= fin_cyc + 6)) begin
      at_end = (exp_evt == EV_OK || exp_evt == EV_ERR) && cyc == exp_cyc;
      if (!finished && !at_end) check(busy_m == 1'b1, "busy during run", busy_m, 1);
      if (finished) begin
        check(busy_m == 1'b0, "busy after done", busy_m, 0);
        check(valid_m == (exp_evt == EV_NONE && m_q != 0), "valid held", valid_m, m_q != 0);
      end
      // tester requests
      if (exp_evt == EV_TEST && cyc == exp_cyc) begin
        check(ts_m == 1'b1, "test_start timing", ts_m, 1);
        check(tn_m == exp_n, "test_n replay", tn_m, exp_n);
        check(tn_m[7] && tn_m[0], "test_n msb/lsb", tn_m, exp_n);
        check(!sieved(tn_m), "test_n sieve", tn_m, exp_n);
        if (m_phase == 1) begin
          check(tn_m != m_p, "Q candidate equals P", tn_m, m_p);
          check(p_m == m_p, "P held in Q phase", p_m, m_p);
        end
        n_starts++;
        case (s.mode)
          0: verdict = is_prime_f(exp_n);
          1: verdict = 1'b0;
          2: verdict = (exp_n == 251);
          default: verdict = 1'($urandom_range(0, 1));
        endcase
        waiting = 1'b1; cur_n = exp_n; hold_n = tn_m;
        start_cyc = cyc; done_cyc = cyc + s.lat; exp_evt = EV_NONE;
      end else if (ts_m) begin
        check(1'b0, "unexpected test_start", tn_m, exp_cyc);
      end
      if (waiting && cyc != start_cyc) check(tn_m == hold_n, "test_n stable", tn_m, hold_n);
      // completion
      if (at_end) begin
        check(done_m == 1'b1, "done timing", done_m, 1);
        check(busy_m == 1'b0, "busy low at done", busy_m, 0);
        if (exp_evt == EV_OK) begin
          check(valid_m == 1'b1 && error_m == 1'b0, "ok flags", {valid_m, error_m}, 2);
          check(p_m == m_p, "P result", p_m, m_p);
          check(q_m == m_q, "Q result", q_m, m_q);
          check(p_m != q_m, "P differs from Q", q_m, p_m);
          if (s.mode == 0) begin
            check(is_prime_f(p_m) && p_m >= 129, "P prime in range", p_m, m_p);
            check(is_prime_f(q_m) && q_m >= 129, "Q prime in range", q_m, m_q);
          end
          exp_evt = EV_NONE;
        end else begin
          check(valid_m == 1'b0 && error_m == 1'b1, "error flags", {valid_m, error_m}, 1);
          check(p_m == 8'd0 && q_m == 8'd0, "P/Q cleared on error", {p_m, q_m}, 0);
          m_q = 0; exp_evt = EV_NONE;
        end
        if (done_m) n_dones++;
        r_p = p_m; r_q = q_m; r_dc = cyc;
        if (s.exp_valid >= 0) check(valid_m == s.exp_valid[0], "table valid", valid_m, s.exp_valid);
        if (s.exp_error >= 0) check(error_m == s.exp_error[0], "table error", error_m, s.exp_error);
        finished = 1'b1; fin_cyc = cyc;
      end else if (done_m) begin
        n_dones++;
        check(1'b0, "unexpected done", cyc, exp_cyc);
      end
      // drive tester and start for the next edge
      if (waiting && cyc == done_cyc) begin
        test_done = 1'b1; test_is_prime = verdict; waiting = 1'b0;
        if (verdict && m_phase == 0) begin
          m_p = cur_n; m_phase = 1; m_att = 0; m_edge = done_cyc + 2;
          predict(m_edge, m_att, m_phase, m_p, maxa, exp_evt, exp_cyc, exp_n);
        end else if (verdict) begin
          m_q = cur_n; exp_evt = EV_OK; exp_cyc = done_cyc + 2;
        end else begin
          m_edge = done_cyc + 2;
          predict(m_edge, m_att, m_phase, m_p, maxa, exp_evt, exp_cyc, exp_n);
        end
      end else begin
        test_done = s.stray && !waiting && ($urandom_range(0, 3) == 0);
        test_is_prime = 1'($urandom_range(0, 1));
      end
      start = s.spam && busy_m && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      cyc++;
    end
    test_done = 1'b0; start = 1'b0;
    if (!finished) check(1'b0, "run timeout", cyc, LIMIT);
    check(n_dones == 1, "single done pulse", n_dones, 1);
    if (s.mode == 1) check(n_starts <= maxa, "test_start count", n_starts, maxa);
    if (s.mode == 2) check(m_p == 251, "P is 251", m_p, 251);
  endtask

  initial begin
    int p0, q0, dc0, p1, q1, dc1, pd, qd, dd;
    bit found;
    tbl[0] = '{8'h01, 1'b0, 0, 3,  1'b0, 1'b0,  1, 0};
    tbl[1] = '{8'h01, 1'b1, 1, 3,  1'b0, 1'b0,  0, 1};
    tbl[2] = '{8'hFB, 1'b0, 2, 3,  1'b0, 1'b0,  0, 1};
    tbl[3] = '{8'h01, 1'b0, 0, 10, 1'b1, 1'b0,  1, 0};
    tbl[4] = '{8'($urandom), 1'b0, 0, int'($urandom_range(1, 6)), 1'b1, 1'b1, 1, 0};
    tbl[5] = '{8'($urandom), 1'b0, 3, int'($urandom_range(1, 6)), 1'b1, 1'b1, -1, -1};
    tbl[6] = '{8'($urandom), 1'b1, 3, int'($urandom_range(1, 4)), 1'b0, 1'b1, -1, -1};

    p0 = 0; q0 = 0; dc0 = 0;
    apply_reset();
    check(a_rounds == 4'd2, "test_rounds A", a_rounds, 2);
    check(b_rounds == 4'd5, "test_rounds B", b_rounds, 5);

    for (int i = 0; i < 7; i++) begin
      run_scen(tbl[i], 1'b1, pd, qd, dd);
      if (i == 0) begin
        p0 = pd; q0 = qd; dc0 = dd;
      end
    end

    // Reset while waiting on the tester, then a stale test_done pulse.
    sel = 1'b0;
    apply_reset();
    @(negedge clk);
    start = 1'b1; seed = 8'h01;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (a_ts) found = 1'b1;
      else @(negedge clk);
    end
    check(found, "test_start before reset", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset in wait");
    @(negedge clk);
    @(negedge clk);
    test_done = 1'b1; test_is_prime = 1'b1;
    @(negedge clk);
    test_done = 1'b0; test_is_prime = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_reset_vals("after stale test_done");
      @(negedge clk);
    end

    // A seed of zero must reproduce the seed=1 run exactly.
    run_scen('{8'h00, 1'b0, 0, 3, 1'b0, 1'b0, 1, 0}, 1'b0, p1, q1, dc1);
    check(p1 == p0, "seed0 P matches seed1", p1, p0);
    check(q1 == q0, "seed0 Q matches seed1", q1, q0);
    check(dc1 == dc0, "seed0 latency matches seed1", dc1, dc0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
